// File: rtl/regfile_arbiter_if.sv
// Request/acknowledge bundle between two requesters and the shared register file.
// The master drives both request channels, and the slave answers with acks, read data and busy.
interface regfile_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_we;
    logic [4:0]        req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid;
    logic              req1_we;
    logic [4:0]        req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  ack0, ack1, rdata, busy
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output ack0, ack1, rdata, busy
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-port round-robin arbiter in front of a 32-entry register file.
// After reset, the block clears the array with a 32-cycle sweep. It then serves one access every two cycles.
module regfile_arbiter #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {INIT, IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [4:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic              grant1;

    logic [DATA_W-1:0] regs [NREGS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        grant1  = 1'b0;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = IDLE;
            end
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    // Requester 1 wins when it is alone, or when both are valid and the pointer favours it.
                    grant1  = bus.req1_valid && (!bus.req0_valid || ptr_q);
                    id_d    = grant1;
                    we_d    = grant1 ? bus.req1_we    : bus.req0_we;
                    addr_d  = grant1 ? bus.req1_addr  : bus.req0_addr;
                    wdata_d = grant1 ? bus.req1_wdata : bus.req0_wdata;
                    ptr_d   = !grant1;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = IDLE;
            default: state_d = INIT;
        endcase
        ack0_d = (state_d == ACCESS) && !id_d;
        ack1_d = (state_d == ACCESS) && id_d;
        busy_d = (state_d == INIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    // The array has no reset and is cleared only by the sweep. Holding rst_n low blocks any commit that is still pending.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == INIT)
                regs[cnt_q] <= '0;
            else if (state_q == ACCESS && we_q && addr_q != 5'd0)
                regs[addr_q] <= wdata_q;
        end
    end

    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = (state_q == ACCESS && !we_q && addr_q != 5'd0) ? regs[addr_q] : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter. It covers the init sweep, single accesses, round-robin pairs,
// register 0, abort on reset, and requests held off during init.
module tb_regfile_arbiter;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    int   n;

    regfile_arbiter_if #(.DATA_W(32)) bus ();

    regfile_arbiter #(.DATA_W(32), .NREGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_requests();
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    endtask

    task automatic set_request(input bit id, input bit we, input logic [4:0] addr, input logic [31:0] wd);
        if (!id) begin
            bus.req0_valid = 1'b1; bus.req0_we = we; bus.req0_addr = addr; bus.req0_wdata = wd;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_we = we; bus.req1_addr = addr; bus.req1_wdata = wd;
        end
    endtask

    task automatic drop_request(input bit id);
        if (!id) bus.req0_valid = 1'b0;
        else     bus.req1_valid = 1'b0;
    endtask

    // Starts and ends on a falling edge with the DUT in IDLE.
    task automatic apply_stimulus(input string tag, input bit id, input bit we,
                                  input logic [4:0] addr, input logic [31:0] wd,
                                  input logic [31:0] exp_rd);
        set_request(id, we, addr, wd);
        @(negedge clk);
        check_output({tag, "_ack0"}, {31'd0, bus.ack0}, {31'd0, !id});
        check_output({tag, "_ack1"}, {31'd0, bus.ack1}, {31'd0, id});
        check_output({tag, "_rdata"}, bus.rdata, we ? 32'd0 : exp_rd);
        drop_request(id);
        @(negedge clk);
        check_output({tag, "_idle_acks"}, {30'd0, bus.ack1, bus.ack0}, 32'd0);
        check_output({tag, "_idle_rdata"}, bus.rdata, 32'd0);
    endtask

    task automatic apply_pair(input string tag, input bit first,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] e0, input logic [31:0] e1);
        set_request(1'b0, 1'b0, a0, 32'd0);
        set_request(1'b1, 1'b0, a1, 32'd0);
        @(negedge clk);
        check_output({tag, "_first_acks"}, {30'd0, bus.ack1, bus.ack0}, first ? 32'd2 : 32'd1);
        check_output({tag, "_first_rdata"}, bus.rdata, first ? e1 : e0);
        drop_request(first);
        @(negedge clk);
        check_output({tag, "_gap_acks"}, {30'd0, bus.ack1, bus.ack0}, 32'd0);
        @(negedge clk);
        check_output({tag, "_second_acks"}, {30'd0, bus.ack1, bus.ack0}, first ? 32'd1 : 32'd2);
        check_output({tag, "_second_rdata"}, bus.rdata, first ? e0 : e1);
        drop_request(!first);
        @(negedge clk);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        clear_requests();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_busy", {31'd0, bus.busy}, 32'd1);
        check_output("reset_acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        check_output("reset_rdata", bus.rdata, 32'd0);

        // The sweep must hold busy high for exactly 32 cycles.
        rst_n = 1'b1;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_output("init_busy_cycles", n, 32'd32);

        apply_stimulus("rd6",  1'b0, 1'b0, 5'd6,  32'd0, 32'd0);
        apply_stimulus("rd28", 1'b1, 1'b0, 5'd28, 32'd0, 32'd0);
        apply_stimulus("rd31", 1'b0, 1'b0, 5'd31, 32'd0, 32'd0);

        apply_stimulus("wr5",  1'b0, 1'b1, 5'd5, 32'hAEAEAE05, 32'd0);
        apply_stimulus("rd5",  1'b1, 1'b0, 5'd5, 32'd0, 32'hAEAEAE05);
        apply_stimulus("wr30", 1'b0, 1'b1, 5'd30, 32'hAEAEAE1E, 32'd0);
        apply_stimulus("wr31", 1'b1, 1'b1, 5'd31, 32'hAEAEAE1F, 32'd0);

        // The pointer favours requester 0 here, because requester 1 won the last grant.
        apply_pair("pair_a", 1'b0, 5'd30, 5'd31, 32'hAEAEAE1E, 32'hAEAEAE1F);
        apply_pair("pair_b", 1'b0, 5'd30, 5'd31, 32'hAEAEAE1E, 32'hAEAEAE1F);
        apply_stimulus("rd30_solo", 1'b0, 1'b0, 5'd30, 32'd0, 32'hAEAEAE1E);
        apply_pair("pair_c", 1'b1, 5'd30, 5'd31, 32'hAEAEAE1E, 32'hAEAEAE1F);

        apply_stimulus("wr0", 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 32'd0);
        apply_stimulus("rd0", 1'b1, 1'b0, 5'd0, 32'd0, 32'd0);

        apply_stimulus("wr12", 1'b0, 1'b1, 5'd12, 32'hAEAEAE0C, 32'd0);
        apply_stimulus("rd12", 1'b0, 1'b0, 5'd12, 32'd0, 32'hAEAEAE0C);

        // Abort a write to register 12 by asserting reset mid-ACCESS.
        set_request(1'b0, 1'b1, 5'd12, 32'h12345678);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_output("abort_acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        check_output("abort_busy", {31'd0, bus.busy}, 32'd1);
        clear_requests();
        @(negedge clk);
        rst_n = 1'b1;
        set_request(1'b0, 1'b0, 5'd12, 32'd0);
        n = 0;
        while (bus.busy && n < 100) begin
            check_output("init_holdoff_ack0", {31'd0, bus.ack0}, 32'd0);
            n++;
            @(negedge clk);
        end
        check_output("reinit_busy_cycles", n, 32'd32);
        check_output("first_idle_ack0", {31'd0, bus.ack0}, 32'd0);
        @(negedge clk);
        check_output("held_ack0", {31'd0, bus.ack0}, 32'd1);
        check_output("held_rd12_rdata", bus.rdata, 32'd0);
        clear_requests();
        @(negedge clk);
        check_output("final_acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
